// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the trainer CPU sequencer and execute stage:
// instruction field positions, the HALT opcode and the fetch FSM encoding.
package cpu_seq_pkg;

  localparam logic [3:0] OP_HALT = 4'hF;

  // Instruction word layout: {opcode[7:4], dst[3:2], src[1:0]}
  localparam int OP_MSB  = 7;
  localparam int OP_LSB  = 4;
  localparam int DST_MSB = 3;
  localparam int DST_LSB = 2;
  localparam int SRC_MSB = 1;
  localparam int SRC_LSB = 0;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  function automatic logic [3:0] instr_opcode(input logic [7:0] word);
    return word[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/prog_ram.sv
// Program store: synchronous write, registered read with one cycle of latency.
module prog_ram #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/instr_seq_fetch.sv
// Instruction sequencer: holds a switch-entered program and replays it one word
// at a time to the execute stage, on a step button or a free-running tick.
module instr_seq_fetch
  import cpu_seq_pkg::*;
#(
  parameter int ADDR_W  = 4,
  parameter int RUN_DIV = 25_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        dip_in,
  input  logic              load_btn,
  input  logic              step_btn,
  input  logic              clr_btn,
  input  logic              run_sw,
  input  logic              exec_ready,
  output logic [7:0]        instr_out,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W:0]   prog_len,
  output logic              prog_full,
  output logic              halted,
  output logic [1:0]        state_dbg
);

  localparam int CNT_W = (RUN_DIV > 2) ? $clog2(RUN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RUN_DIV - 1);
  localparam logic [ADDR_W:0]  DEPTH    = (ADDR_W+1)'(2**ADDR_W);

  // Handshake to execute stage: a word transfers on the edge where the FSM is
  // in ISSUE and exec_ready is high; instr_valid is high for the following cycle.

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [CNT_W-1:0]  tick_cnt;
  logic              run_tick;
  logic              trigger;
  logic              load_ok;
  logic [7:0]        rd_data;
  logic [ADDR_W:0]   pc_inc;
  logic [ADDR_W-1:0] pc_next;

  assign prog_full = (prog_len == DEPTH);
  assign run_tick  = run_sw && (tick_cnt == CNT_LAST);
  assign trigger   = step_btn || run_tick;
  assign load_ok   = load_btn && !clr_btn && (state == ST_IDLE) && !run_sw && !prog_full;
  assign pc_inc    = {1'b0, pc} + (ADDR_W+1)'(1);
  assign pc_next   = (pc_inc == prog_len) ? '0 : pc_inc[ADDR_W-1:0];
  assign pc_out    = pc;
  assign state_dbg = state;

  prog_ram #(.ADDR_W(ADDR_W), .DATA_W(8)) u_ram (
    .clk     (clk),
    .we      (load_ok),
    .wr_addr (prog_len[ADDR_W-1:0]),
    .wr_data (dip_in),
    .rd_addr (pc),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      tick_cnt <= '0;
    end else if (!run_sw || tick_cnt == CNT_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      pc          <= '0;
      prog_len    <= '0;
      instr_out   <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      if (clr_btn) begin
        state    <= ST_IDLE;
        pc       <= '0;
        prog_len <= '0;
        halted   <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            // A load pulse masks any step in the same cycle, accepted or not.
            if (load_btn) begin
              if (load_ok) begin
                prog_len <= prog_len + (ADDR_W+1)'(1);
              end
            end else if (trigger && prog_len != '0 && !halted) begin
              state <= ST_FETCH;
            end
          end
          ST_FETCH: state <= ST_ISSUE;
          ST_ISSUE: begin
            if (instr_opcode(rd_data) == OP_HALT) begin
              halted <= 1'b1;
              state  <= ST_HALT;
            end else if (exec_ready) begin
              instr_out   <= rd_data;
              instr_valid <= 1'b1;
              pc          <= pc_next;
              state       <= ST_IDLE;
            end
          end
          ST_HALT: state <= ST_HALT;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_seq_fetch.sv
// Directed bench for instr_seq_fetch with RUN_DIV=8 and a 16-entry program.
module tb_instr_seq_fetch;
  import cpu_seq_pkg::*;

  localparam int ADDR_W  = 4;
  localparam int RUN_DIV = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        dip_in;
  logic              load_btn, step_btn, clr_btn, run_sw, exec_ready;
  logic [7:0]        instr_out;
  logic              instr_valid;
  logic [ADDR_W-1:0] pc_out;
  logic [ADDR_W:0]   prog_len;
  logic              prog_full;
  logic              halted;
  logic [1:0]        state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  instr_seq_fetch #(.ADDR_W(ADDR_W), .RUN_DIV(RUN_DIV)) dut (
    .clk         (clk),
    .rst         (rst),
    .dip_in      (dip_in),
    .load_btn    (load_btn),
    .step_btn    (step_btn),
    .clr_btn     (clr_btn),
    .run_sw      (run_sw),
    .exec_ready  (exec_ready),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .pc_out      (pc_out),
    .prog_len    (prog_len),
    .prog_full   (prog_full),
    .halted      (halted),
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every strobe must match the oldest expected word.
  always @(negedge clk) begin
    if (rst && instr_valid === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_strobe", {24'd0, instr_out}, 32'hFFFF_FFFF);
      else check("strobe_word", {24'd0, instr_out}, {24'd0, exp_q.pop_front()});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    dip_in = v; load_btn = 1'b1; cyc(); load_btn = 1'b0;
  endtask

  task automatic do_step();
    step_btn = 1'b1; cyc(); step_btn = 1'b0;
  endtask

  task automatic do_clr();
    clr_btn = 1'b1; cyc(); clr_btn = 1'b0;
  endtask

  // Step, then confirm the strobe appears exactly after the third edge.
  task automatic step_expect(input logic [7:0] word, input logic [ADDR_W-1:0] exp_pc);
    exp_q.push_back(word);
    do_step();
    check("lat_k0_valid", {31'd0, instr_valid}, 32'd0);
    cyc();
    check("lat_k1_valid", {31'd0, instr_valid}, 32'd0);
    cyc();
    check("lat_k2_valid", {31'd0, instr_valid}, 32'd1);
    check("lat_k2_word", {24'd0, instr_out}, {24'd0, word});
    check("lat_k2_pc", {28'd0, pc_out}, {28'd0, exp_pc});
    cyc();
    check("strobe_one_cycle", {31'd0, instr_valid}, 32'd0);
  endtask

  initial begin
    int strobes;
    rst = 1'b0; dip_in = '0; load_btn = 0; step_btn = 0; clr_btn = 0;
    run_sw = 0; exec_ready = 1'b1;
    cyc(); cyc();
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_out", {24'd0, instr_out}, 32'd0);
    check("rst_pc", {28'd0, pc_out}, 32'd0);
    check("rst_len", {27'd0, prog_len}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});
    rst = 1'b1;
    cyc();

    // 1: three-word program replayed by step pulses
    do_load(8'h15); do_load(8'h26); do_load(8'h37);
    check("t1_len", {27'd0, prog_len}, 32'd3);
    step_expect(8'h15, 4'd1);
    step_expect(8'h26, 4'd2);
    step_expect(8'h37, 4'd0);

    // 2: fill all entries, extra load ignored, first entry intact
    do_clr();
    for (int i = 0; i < 16; i++) begin
      check("t2_not_full", {31'd0, prog_full}, 32'd0);
      do_load(8'h10 + 8'(i));
    end
    check("t2_full", {31'd0, prog_full}, 32'd1);
    do_load(8'hAA);
    check("t2_len_17th", {27'd0, prog_len}, 32'd16);
    check("t2_full_17th", {31'd0, prog_full}, 32'd1);
    step_expect(8'h10, 4'd1);

    // 3: execute stage stalls for five cycles in ISSUE
    exec_ready = 1'b0;
    do_step(); cyc(); cyc();
    for (int i = 0; i < 4; i++) begin
      check("t3_stall_valid", {31'd0, instr_valid}, 32'd0);
      check("t3_stall_pc", {28'd0, pc_out}, 32'd1);
      check("t3_stall_state", {30'd0, state_dbg}, {30'd0, ST_ISSUE});
      cyc();
    end
    check("t3_stall_valid_last", {31'd0, instr_valid}, 32'd0);
    exp_q.push_back(8'h11);
    exec_ready = 1'b1;
    cyc();
    check("t3_release_valid", {31'd0, instr_valid}, 32'd1);
    check("t3_release_word", {24'd0, instr_out}, 32'h11);
    check("t3_release_pc", {28'd0, pc_out}, 32'd2);
    cyc();

    // 4: run mode stops at HALT
    do_clr();
    do_load(8'h15); do_load(8'hF0);
    exp_q.push_back(8'h15);
    run_sw = 1'b1;
    strobes = 0;
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (instr_valid) strobes++;
    end
    check("t4_strobes", strobes, 32'd1);
    check("t4_halted", {31'd0, halted}, 32'd1);
    check("t4_pc", {28'd0, pc_out}, 32'd1);
    check("t4_state", {30'd0, state_dbg}, {30'd0, ST_HALT});
    do_step(); cyc(); cyc(); cyc();
    check("t4_step_in_halt", {31'd0, halted}, 32'd1);
    run_sw = 1'b0;
    do_clr();
    check("t4_clr_halted", {31'd0, halted}, 32'd0);
    check("t4_clr_len", {27'd0, prog_len}, 32'd0);
    check("t4_clr_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});

    // 5: simultaneous buttons, then step on an empty program
    do_load(8'h22);
    dip_in = 8'h44; clr_btn = 1; load_btn = 1; step_btn = 1;
    cyc();
    clr_btn = 0; load_btn = 0; step_btn = 0;
    check("t5_len", {27'd0, prog_len}, 32'd0);
    cyc(); cyc(); cyc();
    check("t5_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});
    do_step(); cyc(); cyc(); cyc();
    check("t5_empty_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});
    check("t5_empty_pc", {28'd0, pc_out}, 32'd0);

    // 6: reset while in FETCH
    do_load(8'h26); do_load(8'h37);
    exp_q.push_back(8'h26);
    step_expect(8'h26, 4'd1);
    do_step();
    check("t6_fetch", {30'd0, state_dbg}, {30'd0, ST_FETCH});
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    check("t6_valid", {31'd0, instr_valid}, 32'd0);
    check("t6_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});
    check("t6_pc", {28'd0, pc_out}, 32'd0);
    check("t6_len", {27'd0, prog_len}, 32'd0);
    check("t6_out", {24'd0, instr_out}, 32'd0);
    cyc(); cyc(); cyc();

    // step_expect pushed 0x26 too; drop the surplus entry from the manual push
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
